mem_stage_lsu: RTL
==================

Name: mem_stage_lsu

Overview:
Load/store unit for the memory (M) stage of the RV32I 5-stage pipeline. It consumes the execute→memory register outputs (ALU address, store data, memory-write/read controls, funct3) and performs byte-lane alignment, request/ready handshaking to a variable-latency data memory, and load sign/zero extension. While an access is outstanding it raises a stall that holds the E/M register (drives its `en`) and the upstream stages. Its loaded data feeds the memory→writeback register.

Parameters:
- TIMEOUT, 255, max cycles to wait for `mem_ready` before aborting with a bus error (1..65535).
- CNT_W, 16, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ALUResultM  in  32  effective byte address.
- WriteDataM  in  32  store source (rs2).
- funct3M  in  3  access size/sign, from InstrM[14:12].
- MemWriteM  in  1  store in M stage.
- MemReadM  in  1  load in M stage (ResultSrcM==2'b01).
- mem_ready  in  1  memory accepts write / returns read data this cycle.
- mem_rdata  in  32  word read data, valid with `mem_ready`.
- mem_req  out  1  request valid.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address (`ALUResultM[31:2]`, 2'b00).
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-aligned store data.
- ReadDataM  out  32  extended load result.
- StallM  out  1  holds E/M register and earlier stages.
- MemExcM  out  1  one-cycle pulse: misaligned address / illegal funct3.
- BusErrM  out  1  one-cycle pulse: watchdog timeout.

Behaviour:
- Reset (async, immediate): state IDLE; `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`, `ReadDataM`, `MemExcM`, `BusErrM` all 0; counter 0. `StallM` is 0 in IDLE unless an access is present.
- `MemWriteM` and `MemReadM` both asserted: treated as a store; the read is ignored.
- Legality checks:
  - LB, LBU, SB: always aligned.
  - LH, LHU, SH: require `addr[0]==0`.
  - LW, SW: require `addr[1:0]==0`.
  - Load funct3 in {011, 110, 111} is illegal; store funct3 other than 000/001/010 is illegal.
- FSM states: IDLE, BUSY, DONE.
- IDLE, access present and legal:
  - `StallM=1` combinationally in the same cycle.
  - Latch address, be, wdata, we, funct3 and offset; go to BUSY.
- IDLE, access present and illegal:
  - `MemExcM=1` for that cycle; no request; `StallM=0`; `ReadDataM` := 0 next edge; stay IDLE.
- BUSY:
  - `mem_req=1` with latched `mem_we`, `mem_addr`, `mem_be`, `mem_wdata` held stable; `StallM=1`.
  - Counter increments each cycle.
  - On `mem_ready`: capture the extended load (stores: `ReadDataM` unchanged); clear counter; go to DONE.
  - If the counter reaches TIMEOUT without `mem_ready`: `BusErrM` pulses; `ReadDataM` := 0; go to DONE.
- DONE:
  - `mem_req=0`, `StallM=0`; the pipeline advances on this edge.
  - Go to IDLE unconditionally; the next instruction is evaluated in IDLE, so there is no double issue.
- Minimum latency: a legal access occupies M for 3 cycles (IDLE, BUSY with `mem_ready` in its first cycle, DONE). A zero-wait `mem_ready` is accepted in the first BUSY cycle.
- Outputs outside BUSY: `mem_be`, `mem_wdata`, `mem_we` are 0 outside BUSY.
- Store lanes (off = `addr[1:0]`):
  - SB: be = 1<<off; wdata = {4{rs2[7:0]}}.
  - SH: be = 4'b0011<<off; wdata = {2{rs2[15:0]}}.
  - SW: be = 4'b1111; wdata = rs2.
- Loads:
  - Select byte `rdata[8*off+:8]` or half `rdata[8*off+:16]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- `ReadDataM` holds its value until the next completed load or exception.
- Reset mid-BUSY: `mem_req` drops asynchronously; the transaction is abandoned.

Test Plan:
- SW, addr 0x100, data 0xDEADBEEF, `mem_ready` high immediately → one BUSY cycle with req=1, we=1, addr=0x100, be=1111, wdata=0xDEADBEEF; StallM high for 2 cycles, low in DONE.
- LB, addr 0x203, rdata 0x80AA5511, ready after 3 cycles → be unused, addr=0x200; ReadDataM=0xFFFFFF80; StallM high 4 cycles. Repeat as LBU → 0x00000080.
- SH, addr 0x302, rs2 0x1234ABCD → be=1100, wdata=0xABCDABCD. LH at 0x301 → MemExcM pulse, no mem_req, StallM 0, ReadDataM=0.
- LW, addr 0x400, mem_ready never asserted, TIMEOUT=4 → BusErrM pulses after 4 BUSY cycles; ReadDataM=0; FSM returns to IDLE.
- Reads and writes both asserted, SB, addr 0x001, rs2 0x77 → write issued with be=0010, wdata=0x77777777.
- rst_n low during BUSY → mem_req and StallM drop without waiting for a clock edge; after release, a fresh LW at 0x0 completes normally.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit for the RV32I pipeline.
// Aligns store lanes, handshakes with a variable-latency data memory,
// sign/zero-extends loads and stalls the pipeline while an access is open.
module mem_stage_lsu #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [2:0]  funct3M,
    input  logic        MemWriteM,
    input  logic        MemReadM,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MemExcM,
    output logic        BusErrM
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } StateT;

    StateT            state;
    logic [CNT_W-1:0] waitCnt;
    logic [31:0]      addrQ;
    logic [3:0]       beQ;
    logic [31:0]      wdataQ;
    logic             weQ;
    logic [2:0]       funct3Q;
    logic [1:0]       offQ;

    logic [1:0]       off;
    logic             isStore;
    logic             isLoad;
    logic             accessValid;
    logic             legal;
    logic [3:0]       laneBe;
    logic [31:0]      laneWdata;
    logic [31:0]      shiftedData;
    logic [31:0]      loadExt;
    logic             busy;

    // A store wins when both controls are raised; the read is then ignored
    assign off         = ALUResultM[1:0];
    assign isStore     = MemWriteM;
    assign isLoad      = MemReadM & ~MemWriteM;
    assign accessValid = isStore | isLoad;

    // Alignment and funct3 legality of the access currently in M
    always_comb begin
        legal = 1'b0;
        if (isStore) begin
            case (funct3M)
                3'b000:  legal = 1'b1;
                3'b001:  legal = ~off[0];
                3'b010:  legal = (off == 2'b00);
                default: legal = 1'b0;
            endcase
        end else if (isLoad) begin
            case (funct3M)
                3'b000, 3'b100: legal = 1'b1;
                3'b001, 3'b101: legal = ~off[0];
                3'b010:         legal = (off == 2'b00);
                default:        legal = 1'b0;
            endcase
        end
    end

    // Byte enables and replicated store data for the addressed lanes
    always_comb begin
        laneBe    = 4'b1111;
        laneWdata = WriteDataM;
        case (funct3M[1:0])
            2'b00: begin
                laneBe    = 4'b0001 << off;
                laneWdata = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                laneBe    = 4'b0011 << off;
                laneWdata = {2{WriteDataM[15:0]}};
            end
            default: begin
                laneBe    = 4'b1111;
                laneWdata = WriteDataM;
            end
        endcase
    end

    // Extract and extend the loaded byte/half from the returned word
    always_comb begin
        shiftedData = mem_rdata >> {offQ, 3'b000};
        loadExt     = mem_rdata;
        case (funct3Q)
            3'b000:  loadExt = {{24{shiftedData[7]}}, shiftedData[7:0]};
            3'b100:  loadExt = {24'h000000, shiftedData[7:0]};
            3'b001:  loadExt = {{16{shiftedData[15]}}, shiftedData[15:0]};
            3'b101:  loadExt = {16'h0000, shiftedData[15:0]};
            default: loadExt = mem_rdata;
        endcase
    end

    // Access sequencing, watchdog and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            waitCnt   <= '0;
            addrQ     <= '0;
            beQ       <= '0;
            wdataQ    <= '0;
            weQ       <= 1'b0;
            funct3Q   <= '0;
            offQ      <= '0;
            ReadDataM <= '0;
            BusErrM   <= 1'b0;
        end else begin
            BusErrM <= 1'b0;
            case (state)
                IDLE: begin
                    if (accessValid) begin
                        if (legal) begin
                            addrQ   <= {ALUResultM[31:2], 2'b00};
                            beQ     <= laneBe;
                            wdataQ  <= laneWdata;
                            weQ     <= isStore;
                            funct3Q <= funct3M;
                            offQ    <= off;
                            waitCnt <= '0;
                            state   <= BUSY;
                        end else begin
                            ReadDataM <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        if (!weQ) begin
                            ReadDataM <= loadExt;
                        end
                        waitCnt <= '0;
                        state   <= DONE;
                    end else if (waitCnt == CNT_W'(TIMEOUT - 1)) begin
                        BusErrM   <= 1'b1;
                        ReadDataM <= '0;
                        waitCnt   <= '0;
                        state     <= DONE;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Bus outputs are only live during BUSY; stall/exception are gated by reset
    // so an access still presented while reset is held cannot stall or fault
    assign busy      = (state == BUSY);
    assign mem_req   = busy;
    assign mem_we    = busy & weQ;
    assign mem_addr  = busy ? addrQ : 32'h0;
    assign mem_be    = busy ? beQ : 4'h0;
    assign mem_wdata = busy ? wdataQ : 32'h0;
    assign StallM    = rst_n & (busy | ((state == IDLE) & accessValid & legal));
    assign MemExcM   = rst_n & (state == IDLE) & accessValid & ~legal;

endmodule
